// File: rtl/tluh_protocol_monitor.sv
// Passive TileLink-UH slave-port checker: tracks in-flight requests per source and latches sticky protocol errors.
// Optional watchdog (err[8]) is built only when TLUH_MON_TIMEOUT_EN is defined.
module tluh_protocol_monitor #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int RS      = 4,
  parameter int MAX     = 2,
  parameter int ATOMIC  = 0,
  parameter int MAXSIZE = 2,
  parameter int TIMEOUT = 1024
) (
  input  logic              slave_clock_i,
  input  logic              slave_reset_i,
  input  logic [2:0]        slave_a_opcode,
  input  logic [2:0]        slave_a_param,
  input  logic [3:0]        slave_a_size,
  input  logic [RS-1:0]     slave_a_source,
  input  logic [AW-1:0]     slave_a_address,
  input  logic [DW/8-1:0]   slave_a_mask,
  input  logic [DW-1:0]     slave_a_data,
  input  logic              slave_a_corrupt,
  input  logic              slave_a_valid,
  input  logic              slave_a_ready,
  input  logic [2:0]        slave_d_opcode,
  input  logic [1:0]        slave_d_param,
  input  logic [3:0]        slave_d_size,
  input  logic [RS-1:0]     slave_d_source,
  input  logic              slave_d_denied,
  input  logic [DW-1:0]     slave_d_data,
  input  logic              slave_d_corrupt,
  input  logic              slave_d_valid,
  input  logic              slave_d_ready,
  input  logic              clear_i,
  output logic [RS:0]       outstanding_o,
  output logic [8:0]        error_o,
  output logic [3:0]        first_error_o
);
  localparam int BPB = DW / 8;
  localparam int LB  = $clog2(BPB);
  localparam int NS  = 1 << RS;
  localparam int OW  = RS + 1;
  localparam int AVW = 3 + 3 + 4 + RS + AW + BPB + DW + 1;
  localparam int DVW = 3 + 2 + 4 + RS + 1 + DW + 1;
  localparam logic [3:0]    LB_W      = 4'(LB);
  localparam logic [3:0]    MAXSIZE_W = 4'(MAXSIZE);
  localparam logic [OW-1:0] MAX_W     = OW'(MAX);

  typedef enum logic {IDLE, BURST} burst_e;

  function automatic logic [15:0] beats_m1(input logic [3:0] size);
    return (size > LB_W) ? (16'd1 << (size - LB_W)) - 16'd1 : 16'd0;
  endfunction

  function automatic logic [BPB-1:0] lane_mask(input logic [LB-1:0] off, input logic [3:0] size);
    logic [BPB-1:0] m;
    if (size >= LB_W) m = '1;
    else              m = BPB'((32'd1 << (32'd1 << size)) - 32'd1) << off;
    return m;
  endfunction

  function automatic logic [3:0] lowest_bit(input logic [8:0] v);
    logic [3:0] idx;
    idx = '0;
    for (int i = 8; i >= 0; i--) if (v[i]) idx = 4'(i);
    return idx;
  endfunction

  wire a_fire = slave_a_valid & slave_a_ready;
  wire d_fire = slave_d_valid & slave_d_ready;
  wire [AVW-1:0] a_vec = {slave_a_opcode, slave_a_param, slave_a_size, slave_a_source,
                          slave_a_address, slave_a_mask, slave_a_data, slave_a_corrupt};
  wire [DVW-1:0] d_vec = {slave_d_opcode, slave_d_param, slave_d_size, slave_d_source,
                          slave_d_denied, slave_d_data, slave_d_corrupt};

  logic           a_stall_q, d_stall_q;
  logic [AVW-1:0] a_hold_q;
  logic [DVW-1:0] d_hold_q;

  logic [NS-1:0]  tbl_valid;
  logic [3:0]     tbl_size [NS];
  logic           tbl_data [NS];

  burst_e         a_state, d_state;
  logic [15:0]    a_cnt, d_cnt;
  logic [2:0]     a_op_q, d_op_q;
  logic [3:0]     a_size_q, d_size_q;
  logic [RS-1:0]  a_src_q, d_src_q;
  logic [AW-1:0]  a_addr_q;
  logic           d_known_q;

  logic           timeout_hit;
  logic [OW-1:0]  out_next;
  logic [8:0]     new_err;

  // A-side request decode
  wire        a_first   = a_fire && (a_state == IDLE);
  wire [15:0] a_bm1     = (slave_a_opcode == 3'd0) ? beats_m1(slave_a_size) : 16'd0;
  wire        a_atomic  = (slave_a_opcode == 3'd2) || (slave_a_opcode == 3'd3);
  wire        a_exp_dat = a_atomic || (slave_a_opcode == 3'd4);
  wire [3:0]  al_bits   = (slave_a_size < LB_W) ? slave_a_size : LB_W;
  wire        a_misal   = |(slave_a_address[LB-1:0] & LB'((32'd1 << al_bits) - 32'd1));
  logic       a_op_ok;
  always_comb begin
    // NOTE: every always_comb output gets a default first so no latch can be inferred.
    a_op_ok = 1'b0;
    case (slave_a_opcode)
      3'd0, 3'd1, 3'd4: a_op_ok = (slave_a_param == 3'd0);
      3'd2, 3'd3:       a_op_ok = (ATOMIC != 0);
      default:          a_op_ok = 1'b0;
    endcase
  end
  wire a_size_bad  = (slave_a_size > MAXSIZE_W) || (a_atomic && slave_a_size > LB_W) || a_misal ||
                     (slave_a_mask != lane_mask(slave_a_address[LB-1:0], slave_a_size));
  wire a_burst_bad = a_fire && (a_state == BURST) &&
                     ({slave_a_opcode, slave_a_size, slave_a_source, slave_a_address} !=
                      {a_op_q, a_size_q, a_src_q, a_addr_q});

  // D-side response decode; retire uses the source captured on the first beat
  wire        d_first     = d_fire && (d_state == IDLE);
  wire        d_known     = tbl_valid[slave_d_source];
  wire [15:0] d_bm1       = (slave_d_opcode == 3'd1) ? beats_m1(slave_d_size) : 16'd0;
  wire        d_first_bad = d_first && d_known &&
                            ((slave_d_opcode != {2'b00, tbl_data[slave_d_source]}) ||
                             (slave_d_size != tbl_size[slave_d_source]));
  wire        d_burst_bad = d_fire && (d_state == BURST) &&
                            ({slave_d_opcode, slave_d_size, slave_d_source} != {d_op_q, d_size_q, d_src_q});
  wire        d_last      = d_fire && (((d_state == IDLE) && (d_bm1 == 16'd0)) ||
                                       ((d_state == BURST) && (d_cnt == 16'd1)));
  wire        d_retire    = d_last && ((d_state == IDLE) ? d_known : d_known_q);
  wire [RS-1:0] d_ret_src = (d_state == IDLE) ? slave_d_source : d_src_q;

  always_comb begin
    out_next = outstanding_o;
    if (a_first && !d_retire && outstanding_o != '1)      out_next = outstanding_o + 1'b1;
    else if (d_retire && !a_first && outstanding_o != '0) out_next = outstanding_o - 1'b1;
    new_err    = '0;
    new_err[0] = a_stall_q && (!slave_a_valid || a_vec != a_hold_q);
    new_err[1] = d_stall_q && (!slave_d_valid || d_vec != d_hold_q);
    new_err[2] = a_fire && !a_op_ok;
    new_err[3] = a_fire && a_size_bad;
    new_err[4] = a_first && tbl_valid[slave_a_source] && !(d_retire && d_ret_src == slave_a_source);
    new_err[5] = d_first && !d_known;
    new_err[6] = a_burst_bad || d_first_bad || d_burst_bad;
    new_err[7] = out_next > MAX_W;
    new_err[8] = timeout_hit;
  end

  // NOTE: sequential state is written with non-blocking assignments only.
  always_ff @(posedge slave_clock_i or negedge slave_reset_i) begin
    if (!slave_reset_i) begin
      a_stall_q <= 1'b0;
      d_stall_q <= 1'b0;
      a_hold_q  <= '0;
      d_hold_q  <= '0;
    end else begin
      a_stall_q <= slave_a_valid & ~slave_a_ready;
      d_stall_q <= slave_d_valid & ~slave_d_ready;
      a_hold_q  <= a_vec;
      d_hold_q  <= d_vec;
    end
  end

  // Retire is applied before allocate so a same-cycle reuse of one source is legal
  always_ff @(posedge slave_clock_i or negedge slave_reset_i) begin
    if (!slave_reset_i) begin
      tbl_valid <= '0;
    end else begin
      if (d_retire) tbl_valid[d_ret_src]      <= 1'b0;
      if (a_first)  tbl_valid[slave_a_source] <= 1'b1;
    end
  end

  // NOTE: the table payload has no reset; it is only read while its valid bit is set.
  always_ff @(posedge slave_clock_i) begin
    if (a_first) begin
      tbl_size[slave_a_source] <= slave_a_size;
      tbl_data[slave_a_source] <= a_exp_dat;
    end
  end

  always_ff @(posedge slave_clock_i or negedge slave_reset_i) begin
    if (!slave_reset_i) begin
      a_state  <= IDLE;
      a_cnt    <= '0;
      a_op_q   <= '0;
      a_size_q <= '0;
      a_src_q  <= '0;
      a_addr_q <= '0;
    end else begin
      case (a_state)
        IDLE: if (a_fire && a_bm1 != 16'd0) begin
          a_state  <= BURST;
          a_cnt    <= a_bm1;
          a_op_q   <= slave_a_opcode;
          a_size_q <= slave_a_size;
          a_src_q  <= slave_a_source;
          a_addr_q <= slave_a_address;
        end
        BURST: if (a_fire) begin
          a_cnt <= a_cnt - 16'd1;
          if (a_cnt == 16'd1) a_state <= IDLE;
        end
        default: a_state <= IDLE;
      endcase
    end
  end

  always_ff @(posedge slave_clock_i or negedge slave_reset_i) begin
    if (!slave_reset_i) begin
      d_state   <= IDLE;
      d_cnt     <= '0;
      d_op_q    <= '0;
      d_size_q  <= '0;
      d_src_q   <= '0;
      d_known_q <= 1'b0;
    end else begin
      case (d_state)
        IDLE: if (d_fire && d_bm1 != 16'd0) begin
          d_state   <= BURST;
          d_cnt     <= d_bm1;
          d_op_q    <= slave_d_opcode;
          d_size_q  <= slave_d_size;
          d_src_q   <= slave_d_source;
          d_known_q <= d_known;
        end
        BURST: if (d_fire) begin
          d_cnt <= d_cnt - 16'd1;
          if (d_cnt == 16'd1) d_state <= IDLE;
        end
        default: d_state <= IDLE;
      endcase
    end
  end

`ifdef TLUH_MON_TIMEOUT_EN
  logic [15:0] wd_q;
  always_ff @(posedge slave_clock_i or negedge slave_reset_i) begin
    if (!slave_reset_i)                           wd_q <= '0;
    else if (outstanding_o == '0 || d_fire)       wd_q <= '0;
    else if (wd_q != 16'(TIMEOUT))                wd_q <= wd_q + 16'd1;
  end
  assign timeout_hit = (outstanding_o != '0) && !d_fire && (wd_q == 16'(TIMEOUT - 1));
`else
  // Watchdog not built; TIMEOUT is never negative so err[8] stays 0
  assign timeout_hit = (TIMEOUT < 0);
`endif

  // A clear in the same cycle as a new error keeps the new error
  always_ff @(posedge slave_clock_i or negedge slave_reset_i) begin
    if (!slave_reset_i) begin
      outstanding_o <= '0;
      error_o       <= '0;
      first_error_o <= '0;
    end else begin
      outstanding_o <= out_next;
      if (clear_i) begin
        error_o       <= new_err;
        first_error_o <= (new_err != '0) ? lowest_bit(new_err) : 4'd0;
      end else begin
        error_o <= error_o | new_err;
        if (error_o == '0 && new_err != '0) first_error_o <= lowest_bit(new_err);
      end
    end
  end
endmodule

// File: tb/tb_tluh_protocol_monitor.sv
// Self-checking bench for tluh_protocol_monitor (DW=64, MAX=2, MAXSIZE=4, TIMEOUT=16): directed cases then random legal traffic.
module tb_tluh_protocol_monitor;
  localparam int RS = 4;
  localparam int DW = 64;
`ifdef TLUH_MON_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic [2:0]    a_opcode, a_param, d_opcode;
  logic [3:0]    a_size, d_size;
  logic [RS-1:0] a_source, d_source;
  logic [31:0]   a_address;
  logic [7:0]    a_mask;
  logic [DW-1:0] a_data, d_data;
  logic [1:0]    d_param;
  logic          a_corrupt, a_valid, a_ready, d_denied, d_corrupt, d_valid, d_ready, clear;
  logic [RS:0]   outstanding;
  logic [8:0]    err;
  logic [3:0]    first;

  int checks = 0;
  int errors = 0;

  bit m_valid [16];
  int m_size  [16];
  bit m_get   [16];
  int m_count;

  tluh_protocol_monitor #(
    .AW(32), .DW(DW), .RS(RS), .MAX(2), .ATOMIC(0), .MAXSIZE(4), .TIMEOUT(16)
  ) dut (
    .slave_clock_i(clk), .slave_reset_i(rst_n),
    .slave_a_opcode(a_opcode), .slave_a_param(a_param), .slave_a_size(a_size),
    .slave_a_source(a_source), .slave_a_address(a_address), .slave_a_mask(a_mask),
    .slave_a_data(a_data), .slave_a_corrupt(a_corrupt), .slave_a_valid(a_valid),
    .slave_a_ready(a_ready),
    .slave_d_opcode(d_opcode), .slave_d_param(d_param), .slave_d_size(d_size),
    .slave_d_source(d_source), .slave_d_denied(d_denied), .slave_d_data(d_data),
    .slave_d_corrupt(d_corrupt), .slave_d_valid(d_valid), .slave_d_ready(d_ready),
    .clear_i(clear), .outstanding_o(outstanding), .error_o(err), .first_error_o(first)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Byte lanes a request of 2^size bytes at addr covers on an 8-byte beat
  function automatic logic [7:0] lane_mask(input logic [31:0] addr, input int size);
    int bytes;
    bytes = 1 << size;
    if (bytes >= 8) return 8'hFF;
    return 8'(((1 << bytes) - 1) << (addr % 8));
  endfunction

  task automatic a_send(input int op, input int param, input int size, input int src,
                        input int src2, input logic [31:0] addr, input int stall_max);
    int beats;
    beats = (op == 0 && (1 << size) > 8) ? (1 << size) / 8 : 1;
    for (int b = 0; b < beats; b++) begin
      a_opcode  = 3'(op);
      a_param   = 3'(param);
      a_size    = 4'(size);
      a_source  = RS'((b == 0) ? src : src2);
      a_address = addr;
      a_mask    = lane_mask(addr, size);
      a_data    = {$urandom, $urandom};
      a_valid   = 1'b1;
      a_ready   = 1'b0;
      repeat ($urandom_range(stall_max, 0)) tick();
      a_ready = 1'b1;
      tick();
    end
    a_valid = 1'b0;
    a_ready = 1'b0;
  endtask

  task automatic d_send(input int op, input int size, input int src, input int stall_max);
    int beats;
    beats = (op == 1 && (1 << size) > 8) ? (1 << size) / 8 : 1;
    for (int b = 0; b < beats; b++) begin
      d_opcode = 3'(op);
      d_size   = 4'(size);
      d_source = RS'(src);
      d_data   = {$urandom, $urandom};
      d_valid  = 1'b1;
      d_ready  = 1'b0;
      repeat ($urandom_range(stall_max, 0)) tick();
      d_ready = 1'b1;
      tick();
    end
    d_valid = 1'b0;
    d_ready = 1'b0;
  endtask

  task automatic pulse_clear();
    clear = 1'b1;
    tick();
    clear = 1'b0;
  endtask

  task automatic do_reset(input string tag);
    rst_n = 1'b0;
    #1;
    check({tag, "_rst_out"}, 32'(outstanding), 0);
    check({tag, "_rst_err"}, 32'(err), 0);
    tick();
    rst_n = 1'b1;
    tick();
  endtask

  initial begin
    int s;
    logic [31:0] addr;
    a_opcode = '0; a_param = '0; a_size = '0; a_source = '0; a_address = '0; a_mask = '0;
    a_data = '0; a_corrupt = 1'b0; a_valid = 1'b0; a_ready = 1'b0;
    d_opcode = '0; d_param = '0; d_size = '0; d_source = '0; d_denied = 1'b0; d_data = '0;
    d_corrupt = 1'b0; d_valid = 1'b0; d_ready = 1'b0; clear = 1'b0;
    rst_n = 1'b0;
    repeat (2) tick();
    check("reset_out", 32'(outstanding), 0);
    check("reset_err", 32'(err), 0);
    check("reset_first", 32'(first), 0);
    rst_n = 1'b1;
    tick();

    // Get src 3 answered by AccessAckData two cycles later
    a_send(4, 0, 2, 3, 3, 32'h100, 0);
    check("get_out1", 32'(outstanding), 1);
    repeat (2) tick();
    d_send(1, 2, 3, 0);
    check("get_out0", 32'(outstanding), 0);
    check("get_err", 32'(err), 0);

    // Address changes while stalled
    a_opcode = 3'd4; a_param = '0; a_size = 4'd2; a_source = 4'd10;
    a_address = 32'h100; a_mask = 8'h0F; a_valid = 1'b1; a_ready = 1'b0;
    tick();
    a_address = 32'h104;
    tick();
    check("astab_err", 32'(err), 32'h001);
    check("astab_first", 32'(first), 0);
    a_valid = 1'b0;
    repeat (2) tick();
    pulse_clear();
    check("astab_clr_err", 32'(err), 0);
    check("astab_clr_first", 32'(first), 0);
    check("astab_out", 32'(outstanding), 0);

    // Source reuse, then a mid-run reset empties the table
    a_send(4, 0, 2, 5, 5, 32'h200, 0);
    a_send(4, 0, 2, 5, 5, 32'h204, 0);
    check("reuse_err", 32'(err), 32'h010);
    check("reuse_first", 32'(first), 4);
    check("reuse_out", 32'(outstanding), 2);
    do_reset("reuse");
    d_send(1, 2, 5, 0);
    check("post_rst_unknown", 32'(err), 32'h020);
    check("post_rst_out", 32'(outstanding), 0);
    pulse_clear();

    // Two-beat PutFullData, good then with the source changing on beat 2
    a_send(0, 0, 4, 1, 1, 32'h200, 1);
    check("put_out1", 32'(outstanding), 1);
    d_send(0, 4, 1, 1);
    check("put_err", 32'(err), 0);
    check("put_out0", 32'(outstanding), 0);
    a_send(0, 0, 4, 1, 2, 32'h200, 0);
    check("putbad_err", 32'(err), 32'h040);
    check("putbad_first", 32'(first), 6);
    check("putbad_out", 32'(outstanding), 1);
    d_send(0, 4, 1, 0);
    check("putbad_drain", 32'(outstanding), 0);
    pulse_clear();

    // Unknown D source, clear, then clear colliding with a new error
    d_send(0, 2, 7, 0);
    check("unk_err", 32'(err), 32'h020);
    check("unk_first", 32'(first), 5);
    pulse_clear();
    check("clr_err", 32'(err), 0);
    check("clr_first", 32'(first), 0);
    d_send(0, 2, 7, 0);
    clear = 1'b1;
    a_send(5, 0, 2, 11, 11, 32'h300, 0);
    clear = 1'b0;
    check("clr_vs_err", 32'(err), 32'h004);
    check("clr_vs_first", 32'(first), 2);
    do_reset("clrerr");

    // Illegal param plus misaligned address in one beat
    a_send(1, 1, 2, 6, 6, 32'h102, 0);
    check("multi_err", 32'(err), 32'h00C);
    check("multi_first", 32'(first), 2);
    do_reset("multi");

    // Third outstanding request exceeds MAX
    a_send(4, 0, 2, 1, 1, 32'h10, 0);
    a_send(4, 0, 2, 2, 2, 32'h20, 0);
    check("max_ok", 32'(err), 0);
    a_send(4, 0, 2, 3, 3, 32'h30, 0);
    check("max_err", 32'(err), 32'h080);
    check("max_first", 32'(first), 7);
    check("max_out", 32'(outstanding), 3);
    do_reset("max");

    // Same-cycle retire and reallocate of source 9
    a_send(4, 0, 2, 9, 9, 32'h40, 0);
    a_opcode = 3'd4; a_param = '0; a_size = 4'd2; a_source = 4'd9; a_address = 32'h44;
    a_mask = 8'hF0; a_valid = 1'b1; a_ready = 1'b1;
    d_opcode = 3'd1; d_size = 4'd2; d_source = 4'd9; d_valid = 1'b1; d_ready = 1'b1;
    tick();
    a_valid = 1'b0; a_ready = 1'b0; d_valid = 1'b0; d_ready = 1'b0;
    check("same_err", 32'(err), 0);
    check("same_out", 32'(outstanding), 1);
    d_send(1, 2, 9, 0);
    check("same_drain", 32'(outstanding), 0);

    // Watchdog: request left unanswered
    a_send(4, 0, 2, 4, 4, 32'h50, 0);
    repeat (15) tick();
    check("to_early", 32'(err[8]), 0);
    tick();
    check("to_hit", 32'(err[8]), 32'(TO_EN));
    do_reset("to");

    // Random legal traffic against an in-flight set model
    m_count = 0;
    for (int i = 0; i < 16; i++) m_valid[i] = 1'b0;
    for (int it = 0; it < 40; it++) begin
      if (m_count == 0 || (m_count < 2 && $urandom_range(1, 0) == 0)) begin
        do s = $urandom_range(15, 0); while (m_valid[s]);
        m_get[s]  = ($urandom_range(1, 0) == 1);
        m_size[s] = $urandom_range(4, 0);
        addr = ($urandom & 32'hFFFF) & ~(32'((1 << m_size[s]) - 1));
        a_send(m_get[s] ? 4 : 0, 0, m_size[s], s, s, addr, 1);
        m_valid[s] = 1'b1;
        m_count++;
      end else begin
        do s = $urandom_range(15, 0); while (!m_valid[s]);
        d_send(m_get[s] ? 1 : 0, m_size[s], s, 1);
        m_valid[s] = 1'b0;
        m_count--;
      end
      check($sformatf("rnd%0d_out", it), 32'(outstanding), 32'(m_count));
      check($sformatf("rnd%0d_err", it), 32'(err), 0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/tluh_protocol_monitor.md
Name: tluh_protocol_monitor

Overview:
Synthesizable run-time checker for a TileLink-UH slave port. It passively observes the A and D channels and tracks in-flight requests per source ID. It checks handshake stability, request legality, multi-beat bursts and response matching. Violations are latched into sticky error flags. It sits beside any SRAM/peripheral slave in silicon or FPGA builds and drives no bus signals.

Parameters:
AW, 32, address width
DW, 32, data width in bits (32/64/128); BPB = DW/8 bytes per beat
RS, 4, source ID width; per-source table has 2^RS entries
MAX, 2, maximum legal outstanding requests (width RS+1)
ATOMIC, 0, 1 = ArithmeticData/LogicalData (opcodes 2/3) legal
MAXSIZE, 2, maximum legal a_size (log2 bytes)
TIMEOUT, 1024, watchdog limit in cycles (used only with the optional feature)

Ports:
slave_clock_i  in  1  clock
slave_reset_i  in  1  asynchronous active-low reset
slave_a_opcode/param/size/source/address/mask/data/corrupt/valid/ready  in  3/3/4/RS/AW/BPB/DW/1/1/1  A channel, observed only
slave_d_opcode/param/size/source/denied/data/corrupt/valid/ready  in  3/2/4/RS/1/DW/1/1/1  D channel, observed only
clear_i  in  1  synchronous pulse; clears the error flags only
outstanding_o  out  RS+1  count of requests accepted but not fully answered
error_o  out  9  sticky error flags (bit map below)
first_error_o  out  4  index of the first bit set since reset or clear; valid when error_o != 0

Behaviour:
- Reset (slave_reset_i=0, async): outstanding_o=0, error_o=0, first_error_o=0, table cleared, beat counters 0.
- Fire events: a_fire = a_valid & a_ready; d_fire = d_valid & d_ready. All checks are evaluated on the rising edge. Flags are visible one cycle after the offending edge.
- Beats per message: beats(size) = 1 if 2^size <= BPB, else 2^size/BPB. Only PutFullData (0) on A and AccessAckData (1) on D are multi-beat.
- Error bits:
  - err[0] A stability: after a_valid & !a_ready, the next cycle must hold a_valid=1 and every A field unchanged.
  - err[1] D stability: same rule for the D channel.
  - err[2] illegal A opcode or param: legal opcodes are 0, 1, 4, plus 2/3 when ATOMIC=1. Any param != 0 on opcodes 0/1/4 is illegal.
  - err[3] size or alignment: a_size > MAXSIZE; atomic with 2^size > BPB; address not aligned to min(2^size, BPB); or a_mask != the lane mask implied by address/size.
  - err[4] source reuse: first-beat a_fire whose source entry is already valid.
  - err[5] D unknown source: first-beat d_fire whose source entry is not valid.
  - err[6] D mismatch: d_opcode != expected (Get/atomic -> 1, Put -> 0), d_size != stored size, or source changes mid-burst.
  - err[7] outstanding > MAX.
  - err[8] timeout (optional feature).
- A burst FSM: IDLE -> (first-beat a_fire with beats>1) -> BURST with counter = beats-1. Each a_fire decrements the counter. At 0 -> IDLE. In BURST, opcode/size/source/address must equal the first beat, otherwise err[6]. The table entry is allocated on the first beat.
- D burst FSM: same structure keyed on d_fire. The entry retires on the last D beat.
- outstanding_o: +1 on first-beat A allocate, -1 on last-beat D retire, unchanged when both happen in the same cycle. It saturates at 0 and 2^(RS+1)-1 and never wraps.
- Same-cycle retire and allocate on the same source is legal: the retire is applied first, so err[4] is not raised.
- Multiple errors in one cycle: all flags are set; first_error_o takes the lowest index.
- clear_i clears error_o and first_error_o but not the tracking state. If an error occurs in the same cycle as clear_i, the error wins.
- Reset mid-burst aborts both FSMs to IDLE and empties the table.

Optional Feature:
Macro TLUH_MON_TIMEOUT_EN.
- Defined: a 16-bit watchdog counts cycles while outstanding_o != 0 and no d_fire occurs. It resets on d_fire or when outstanding_o == 0. Reaching TIMEOUT sets err[8]; the counter then holds.
- Undefined: no counter logic is built and err[8] is tied 0.

Test Plan:
- Get source 3 size 2 at 0x100, with AccessAckData src 3 size 2 two cycles later -> outstanding_o goes 0->1->0; error_o = 0.
- a_valid=1, a_ready=0, then a_address changes 0x100->0x104 the next cycle -> error_o[0]=1, first_error_o=0.
- Two Gets on source 5 with no D between them -> error_o[4]=1, outstanding_o=2.
- DW=64, PutFullData size 4 (2 beats) on source 1, then AccessAck src 1 -> no error. Repeat with the 2nd beat carrying source 2 -> error_o[6]=1.
- AccessAck on source 7 with nothing in flight -> error_o[5]=1. Then pulse clear_i -> error_o=0.
- With TLUH_MON_TIMEOUT_EN and TIMEOUT=16, a Get with no response -> error_o[8]=1 at cycle 16. Without the macro -> error_o[8] stays 0.
